// File: rtl/vx_axi_write_adapter_pkg.sv
// vx_axi_write_adapter_pkg
// Shared AXI4 constants and helpers for the write adapter.
//   AXI_BURST_INCR : AWBURST encoding for incrementing bursts
//   AXI_RESP_OKAY  : BRESP/RRESP encoding for a normal successful access
//   axi_size()     : AxSIZE encoding for a beat of the given byte count
package vx_axi_write_adapter_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // AxSIZE is log2 of the beat width in bytes; a loop keeps this usable
  // with constant arguments in both simulation and synthesis.
  function automatic logic [2:0] axi_size(input int unsigned bytes);
    logic [2:0] result;
    result = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((32'd1 << i) == bytes) begin
        result = 3'(i);
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/VX_pending_size.sv
// VX_pending_size
// Counter of outstanding transactions with empty/full status.
//   clk, reset : clock, asynchronous active-low reset
//   incr       : one transaction enters (caller must not assert when full)
//   decr       : one transaction leaves; ignored while empty
//   empty/full : count == 0 / count == SIZE
//   size       : current count
module VX_pending_size #(
  parameter int SIZE  = 16,
  parameter int SIZEW = $clog2(SIZE + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             incr,
  input  logic             decr,
  output logic             empty,
  output logic             full,
  output logic [SIZEW-1:0] size
);

  logic [SIZEW-1:0] count;
  logic             decr_eff;

  // A decrement with nothing outstanding is dropped so the count never wraps.
  assign decr_eff = decr && (count != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (incr && !decr_eff) begin
      count <= count + 1'b1;
    end else if (!incr && decr_eff) begin
      count <= count - 1'b1;
    end
  end

  assign empty = (count == '0);
  assign full  = (count == SIZEW'(SIZE));
  assign size  = count;

endmodule

// File: rtl/vx_axi_write_adapter.sv
// vx_axi_write_adapter
// Turns single-beat core memory write requests into AXI4 AW/W transactions
// and hands B responses back as tagged acknowledgements.
//   clk, reset        : clock, asynchronous active-low reset
//   mem_req_*         : write request (valid/ready, word address, data, byteen, tag)
//   mem_rsp_*         : acknowledgement (valid/ready, tag), pass-through of B
//   m_axi_aw*/w*/b*   : AXI4 write master channels
//   pending_count     : writes accepted but not yet acknowledged on B
//   error             : sticky flag for non-OKAY or unexpected B responses
module vx_axi_write_adapter
  import vx_axi_write_adapter_pkg::*;
#(
  parameter int DATA_WIDTH     = 512,
  parameter int MEM_ADDR_WIDTH = 26,
  parameter int ADDR_WIDTH     = MEM_ADDR_WIDTH + $clog2(DATA_WIDTH / 8),
  parameter int TAG_WIDTH      = 8,
  parameter int MAX_PENDING    = 16
) (
  input  logic                             clk,
  input  logic                             reset,

  input  logic                             mem_req_valid,
  output logic                             mem_req_ready,
  input  logic [MEM_ADDR_WIDTH-1:0]        mem_req_addr,
  input  logic [DATA_WIDTH-1:0]            mem_req_data,
  input  logic [DATA_WIDTH/8-1:0]          mem_req_byteen,
  input  logic [TAG_WIDTH-1:0]             mem_req_tag,

  output logic                             mem_rsp_valid,
  input  logic                             mem_rsp_ready,
  output logic [TAG_WIDTH-1:0]             mem_rsp_tag,

  output logic                             m_axi_awvalid,
  input  logic                             m_axi_awready,
  output logic [ADDR_WIDTH-1:0]            m_axi_awaddr,
  output logic [TAG_WIDTH-1:0]             m_axi_awid,
  output logic [7:0]                       m_axi_awlen,
  output logic [2:0]                       m_axi_awsize,
  output logic [1:0]                       m_axi_awburst,
  output logic [1:0]                       m_axi_awlock,
  output logic [3:0]                       m_axi_awcache,
  output logic [2:0]                       m_axi_awprot,
  output logic [3:0]                       m_axi_awqos,
  output logic [3:0]                       m_axi_awregion,

  output logic                             m_axi_wvalid,
  input  logic                             m_axi_wready,
  output logic [DATA_WIDTH-1:0]            m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]          m_axi_wstrb,
  output logic                             m_axi_wlast,

  input  logic                             m_axi_bvalid,
  output logic                             m_axi_bready,
  input  logic [TAG_WIDTH-1:0]             m_axi_bid,
  input  logic [1:0]                       m_axi_bresp,

  output logic [$clog2(MAX_PENDING+1)-1:0] pending_count,
  output logic                             error
);

  localparam int         OFFSET_BITS = $clog2(DATA_WIDTH / 8);
  localparam logic [2:0] BEAT_SIZE   = axi_size(DATA_WIDTH / 8);

  logic [MEM_ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]     req_data;
  logic [DATA_WIDTH/8-1:0]   req_byteen;
  logic [TAG_WIDTH-1:0]      req_tag;
  logic                      aw_pend;
  logic                      w_pend;

  logic aw_fire;
  logic w_fire;
  logic b_fire;
  logic req_fire;
  logic pend_full;
  logic pend_empty;

  assign aw_fire  = aw_pend && m_axi_awready;
  assign w_fire   = w_pend && m_axi_wready;
  assign b_fire   = m_axi_bvalid && mem_rsp_ready;
  assign req_fire = mem_req_valid && mem_req_ready;

  // A new request may overwrite the holding register in the same cycle the
  // previous one finishes on both channels, giving full throughput.
  assign mem_req_ready = (!aw_pend || aw_fire)
                      && (!w_pend || w_fire)
                      && !pend_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_addr   <= '0;
      req_data   <= '0;
      req_byteen <= '0;
      req_tag    <= '0;
      aw_pend    <= 1'b0;
      w_pend     <= 1'b0;
    end else if (req_fire) begin
      req_addr   <= mem_req_addr;
      req_data   <= mem_req_data;
      req_byteen <= mem_req_byteen;
      req_tag    <= mem_req_tag;
      aw_pend    <= 1'b1;
      w_pend     <= 1'b1;
    end else begin
      if (aw_fire) begin
        aw_pend <= 1'b0;
      end
      if (w_fire) begin
        w_pend <= 1'b0;
      end
    end
  end

  VX_pending_size #(
    .SIZE (MAX_PENDING)
  ) pending_size (
    .clk   (clk),
    .reset (reset),
    .incr  (req_fire),
    .decr  (b_fire),
    .empty (pend_empty),
    .full  (pend_full),
    .size  (pending_count)
  );

  // A response with nothing outstanding means the slave and this adapter
  // disagree about what is in flight; record it alongside slave errors.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error <= 1'b0;
    end else if (b_fire && ((m_axi_bresp != AXI_RESP_OKAY) || pend_empty)) begin
      error <= 1'b1;
    end
  end

  assign m_axi_awvalid  = aw_pend;
  assign m_axi_awaddr   = ADDR_WIDTH'({req_addr, {OFFSET_BITS{1'b0}}});
  assign m_axi_awid     = req_tag;
  assign m_axi_awlen    = 8'd0;
  assign m_axi_awsize   = BEAT_SIZE;
  assign m_axi_awburst  = AXI_BURST_INCR;
  assign m_axi_awlock   = 2'b00;
  assign m_axi_awcache  = 4'd0;
  assign m_axi_awprot   = 3'd0;
  assign m_axi_awqos    = 4'd0;
  assign m_axi_awregion = 4'd0;

  assign m_axi_wvalid = w_pend;
  assign m_axi_wdata  = req_data;
  assign m_axi_wstrb  = req_byteen;
  assign m_axi_wlast  = 1'b1;

  assign mem_rsp_valid = m_axi_bvalid;
  assign mem_rsp_tag   = m_axi_bid;
  assign m_axi_bready  = mem_rsp_ready;

endmodule

// File: tb/tb_vx_axi_write_adapter.sv
// tb_vx_axi_write_adapter
// Directed bench for vx_axi_write_adapter with a 512-bit bus and an
// outstanding limit of 8, so the throughput fill also reaches the full limit.
module tb_vx_axi_write_adapter;

  localparam int DATA_WIDTH     = 512;
  localparam int MEM_ADDR_WIDTH = 26;
  localparam int ADDR_WIDTH     = MEM_ADDR_WIDTH + 6;
  localparam int TAG_WIDTH      = 8;
  localparam int MAX_PENDING    = 8;
  localparam int CW             = $clog2(MAX_PENDING + 1);

  logic                      clk;
  logic                      reset;
  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic [MEM_ADDR_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0]     mem_req_data;
  logic [DATA_WIDTH/8-1:0]   mem_req_byteen;
  logic [TAG_WIDTH-1:0]      mem_req_tag;
  logic                      mem_rsp_valid;
  logic                      mem_rsp_ready;
  logic [TAG_WIDTH-1:0]      mem_rsp_tag;
  logic                      awvalid, awready;
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic [TAG_WIDTH-1:0]      awid;
  logic [7:0]                awlen;
  logic [2:0]                awsize;
  logic [1:0]                awburst, awlock;
  logic [3:0]                awcache, awqos, awregion;
  logic [2:0]                awprot;
  logic                      wvalid, wready, wlast;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      bvalid, bready;
  logic [TAG_WIDTH-1:0]      bid;
  logic [1:0]                bresp;
  logic [CW-1:0]             pending_count;
  logic                      error;

  int tests_run    = 0;
  int tests_failed = 0;
  int accepted;
  logic [DATA_WIDTH-1:0] pattern;

  vx_axi_write_adapter #(
    .DATA_WIDTH     (DATA_WIDTH),
    .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .TAG_WIDTH      (TAG_WIDTH),
    .MAX_PENDING    (MAX_PENDING)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_byteen (mem_req_byteen),
    .mem_req_tag    (mem_req_tag),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_ready  (mem_rsp_ready),
    .mem_rsp_tag    (mem_rsp_tag),
    .m_axi_awvalid  (awvalid),
    .m_axi_awready  (awready),
    .m_axi_awaddr   (awaddr),
    .m_axi_awid     (awid),
    .m_axi_awlen    (awlen),
    .m_axi_awsize   (awsize),
    .m_axi_awburst  (awburst),
    .m_axi_awlock   (awlock),
    .m_axi_awcache  (awcache),
    .m_axi_awprot   (awprot),
    .m_axi_awqos    (awqos),
    .m_axi_awregion (awregion),
    .m_axi_wvalid   (wvalid),
    .m_axi_wready   (wready),
    .m_axi_wdata    (wdata),
    .m_axi_wstrb    (wstrb),
    .m_axi_wlast    (wlast),
    .m_axi_bvalid   (bvalid),
    .m_axi_bready   (bready),
    .m_axi_bid      (bid),
    .m_axi_bresp    (bresp),
    .pending_count  (pending_count),
    .error          (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [511:0] obs,
                              input logic [511:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [MEM_ADDR_WIDTH-1:0] addr,
                                input logic [TAG_WIDTH-1:0] tag);
    mem_req_valid  = 1'b1;
    mem_req_addr   = addr;
    mem_req_tag    = tag;
    mem_req_data   = pattern ^ DATA_WIDTH'(tag);
    mem_req_byteen = '1;
  endtask

  initial begin
    pattern        = {16{32'hDEADBEEF}};
    reset          = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_addr   = '0;
    mem_req_data   = '0;
    mem_req_byteen = '0;
    mem_req_tag    = '0;
    mem_rsp_ready  = 1'b0;
    awready        = 1'b0;
    wready         = 1'b0;
    bvalid         = 1'b1;
    bid            = 8'h5A;
    bresp          = 2'b00;
    #1;

    // Reset state; B pass-through works even in reset.
    check_output("reset_awvalid", 512'(awvalid), 512'(0));
    check_output("reset_wvalid", 512'(wvalid), 512'(0));
    check_output("reset_pending", 512'(pending_count), 512'(0));
    check_output("reset_error", 512'(error), 512'(0));
    check_output("reset_ready", 512'(mem_req_ready), 512'(1));
    check_output("reset_rsp_valid", 512'(mem_rsp_valid), 512'(1));
    check_output("reset_rsp_tag", 512'(mem_rsp_tag), 512'(8'h5A));
    bvalid = 1'b0;
    tick();
    tick();
    reset = 1'b1;

    // Single write, slave always ready.
    awready       = 1'b1;
    wready        = 1'b1;
    mem_rsp_ready = 1'b1;
    apply_stimulus(26'h10, 8'h03);
    #1;
    check_output("single_ready", 512'(mem_req_ready), 512'(1));
    tick();
    mem_req_valid = 1'b0;
    check_output("single_awvalid", 512'(awvalid), 512'(1));
    check_output("single_wvalid", 512'(wvalid), 512'(1));
    check_output("single_awaddr", 512'(awaddr), 512'(32'h400));
    check_output("single_awid", 512'(awid), 512'(8'h03));
    check_output("single_awlen", 512'(awlen), 512'(0));
    check_output("single_awsize", 512'(awsize), 512'(3'd6));
    check_output("single_awburst", 512'(awburst), 512'(2'b01));
    check_output("single_awmisc", 512'({awlock, awcache, awprot, awqos, awregion}), 512'(0));
    check_output("single_wdata", wdata, pattern ^ 512'(8'h03));
    check_output("single_wstrb", 512'(wstrb), 512'({64{1'b1}}));
    check_output("single_wlast", 512'(wlast), 512'(1));
    check_output("single_pending1", 512'(pending_count), 512'(1));
    tick();
    check_output("single_aw_done", 512'(awvalid), 512'(0));
    check_output("single_w_done", 512'(wvalid), 512'(0));
    bvalid = 1'b1;
    bid    = 8'h03;
    #1;
    check_output("single_rsp_valid", 512'(mem_rsp_valid), 512'(1));
    check_output("single_rsp_tag", 512'(mem_rsp_tag), 512'(8'h03));
    check_output("single_bready", 512'(bready), 512'(1));
    tick();
    bvalid = 1'b0;
    check_output("single_pending0", 512'(pending_count), 512'(0));
    check_output("single_error", 512'(error), 512'(0));

    // AW/W skew: AW stalled for three cycles, W completes first.
    awready = 1'b0;
    apply_stimulus(26'h20, 8'h05);
    #1;
    check_output("skew_first_ready", 512'(mem_req_ready), 512'(1));
    tick();
    apply_stimulus(26'h21, 8'h06);
    #1;
    check_output("skew_ready_c1", 512'(mem_req_ready), 512'(0));
    tick();
    check_output("skew_w_done", 512'(wvalid), 512'(0));
    check_output("skew_aw_held", 512'(awvalid), 512'(1));
    check_output("skew_awaddr_held", 512'(awaddr), 512'(32'h800));
    check_output("skew_ready_c2", 512'(mem_req_ready), 512'(0));
    tick();
    check_output("skew_ready_c3", 512'(mem_req_ready), 512'(0));
    check_output("skew_awid_held", 512'(awid), 512'(8'h05));
    awready = 1'b1;
    #1;
    check_output("skew_ready_on_aw", 512'(mem_req_ready), 512'(1));
    tick();
    mem_req_valid = 1'b0;
    check_output("skew_second_awid", 512'(awid), 512'(8'h06));
    check_output("skew_pending2", 512'(pending_count), 512'(2));
    tick();
    bvalid = 1'b1;
    bid    = 8'h05;
    #1;
    check_output("skew_rsp_tag5", 512'(mem_rsp_tag), 512'(8'h05));
    tick();
    bid = 8'h06;
    #1;
    check_output("skew_rsp_tag6", 512'(mem_rsp_tag), 512'(8'h06));
    tick();
    bvalid = 1'b0;
    check_output("skew_pending0", 512'(pending_count), 512'(0));

    // Throughput: eight back-to-back requests with B held off, then full.
    accepted = 0;
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(26'(i), 8'(8'h10 + i));
      #1;
      if (mem_req_ready) accepted++;
      tick();
    end
    check_output("thru_accepted", 512'(accepted), 512'(8));
    check_output("thru_pending8", 512'(pending_count), 512'(8));
    check_output("thru_last_awid", 512'(awid), 512'(8'h17));
    apply_stimulus(26'h8, 8'h18);
    #1;
    check_output("full_ready0", 512'(mem_req_ready), 512'(0));
    bvalid = 1'b1;
    bid    = 8'h10;
    #1;
    check_output("full_ready_same_cycle", 512'(mem_req_ready), 512'(0));
    tick();
    bvalid = 1'b0;
    mem_req_valid = 1'b0;
    check_output("full_pending7", 512'(pending_count), 512'(7));
    check_output("full_ready_next", 512'(mem_req_ready), 512'(1));
    bvalid = 1'b1;
    for (int i = 1; i < 8; i++) begin
      bid = 8'(8'h10 + i);
      tick();
    end
    bvalid = 1'b0;
    check_output("drain_pending0", 512'(pending_count), 512'(0));
    check_output("drain_error0", 512'(error), 512'(0));

    // Error response is sticky across later OKAY responses.
    apply_stimulus(26'h30, 8'h20);
    tick();
    mem_req_valid = 1'b0;
    tick();
    bvalid = 1'b1;
    bid    = 8'h20;
    bresp  = 2'b10;
    tick();
    bvalid = 1'b0;
    bresp  = 2'b00;
    check_output("err_set", 512'(error), 512'(1));
    check_output("err_pending0", 512'(pending_count), 512'(0));
    apply_stimulus(26'h31, 8'h21);
    tick();
    mem_req_valid = 1'b0;
    tick();
    bvalid = 1'b1;
    bid    = 8'h21;
    tick();
    bvalid = 1'b0;
    check_output("err_sticky", 512'(error), 512'(1));
    check_output("err_pending_after_ok", 512'(pending_count), 512'(0));

    // Reset in the middle of a transaction with two writes outstanding.
    apply_stimulus(26'h40, 8'h30);
    tick();
    apply_stimulus(26'h41, 8'h31);
    tick();
    mem_req_valid = 1'b0;
    awready       = 1'b0;
    wready        = 1'b0;
    #1;
    check_output("mid_awvalid1", 512'(awvalid), 512'(1));
    check_output("mid_pending2", 512'(pending_count), 512'(2));
    #1;
    reset = 1'b0;
    #1;
    check_output("mid_rst_awvalid", 512'(awvalid), 512'(0));
    check_output("mid_rst_wvalid", 512'(wvalid), 512'(0));
    check_output("mid_rst_pending", 512'(pending_count), 512'(0));
    check_output("mid_rst_error", 512'(error), 512'(0));
    tick();
    reset = 1'b1;

    // Unexpected B with nothing outstanding: error, count stays at zero.
    bvalid = 1'b1;
    bid    = 8'h77;
    tick();
    bvalid = 1'b0;
    check_output("underflow_error", 512'(error), 512'(1));
    check_output("underflow_pending", 512'(pending_count), 512'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
